sc_regrandom_ranged: RTL and testbench

SC_REGRANDOM_RANGED -- requirements
Module: sc_regrandom_ranged

---
 rtl/sc_regrandom_pkg.sv | 40 ++++
 rtl/sc_regrandom_lfsr.sv | 57 +++++
 rtl/sc_regrandom_ranged.sv | 164 ++++++++++++++++
 tb/tb_sc_regrandom_ranged.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_regrandom_pkg.sv
// rtl/sc_regrandom_pkg.sv - shared types and constants for the ranged random generator
//
// Purpose: FSM state encoding, maximal-length LFSR tap masks indexed by
// width (4..16), and the default seed shared by the LFSR datapath and the
// draw controller.
// Ports: none (package).

package sc_regrandom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } rr_state_t;

  localparam int unsigned MIN_WIDTH = 4;
  localparam int unsigned MAX_WIDTH = 16;

  localparam logic [15:0] DEFAULT_SEED = 16'h0099;

  // Bit i set means bit [i] of the register feeds the XOR that is shifted
  // into bit 0. Every entry gives a maximal period of 2**W - 1.
  localparam logic [15:0] TAP_TABLE [MIN_WIDTH:MAX_WIDTH] = '{
    16'h000C,  // 4 : [3] [2]
    16'h0014,  // 5 : [4] [2]
    16'h0030,  // 6 : [5] [4]
    16'h0060,  // 7 : [6] [5]
    16'h00B8,  // 8 : [7] [5] [4] [3]
    16'h0110,  // 9 : [8] [4]
    16'h0240,  // 10: [9] [6]
    16'h0500,  // 11: [10] [8]
    16'h0829,  // 12: [11] [5] [3] [0]
    16'h100D,  // 13: [12] [3] [2] [0]
    16'h2015,  // 14: [13] [4] [2] [0]
    16'h6000,  // 15: [14] [13]
    16'hD008   // 16: [15] [14] [12] [3]
  };

endpackage

// File: rtl/sc_regrandom_lfsr.sv
// rtl/sc_regrandom_lfsr.sv - left-shifting Fibonacci LFSR with seed load
//
// Purpose: holds the random state; loads a seed, advances one step when
// asked, and (with SC_REGRANDOM_ZEROGUARD_EN defined) refuses to stay in
// or be loaded with the all-zero lock-up state, substituting SEED instead.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset, state <= SEED
//   load       in   load load_value next edge (highest priority)
//   load_value in   seed value
//   advance    in   shift one step next edge
//   state      out  current register contents

module sc_regrandom_lfsr
  import sc_regrandom_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [15:0]      TAPS_FULL = TAP_TABLE[WIDTH];
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q;
  logic             feedback;

  assign feedback = ^(state_q & TAPS);
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else if (load) begin
`ifdef SC_REGRANDOM_ZEROGUARD_EN
      state_q <= (load_value == '0) ? SEED : load_value;
`else
      state_q <= load_value;
`endif
    end
`ifdef SC_REGRANDOM_ZEROGUARD_EN
    else if (state_q == '0) begin
      state_q <= SEED;
    end
`endif
    else if (advance) begin
      state_q <= {state_q[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/sc_regrandom_ranged.sv
// rtl/sc_regrandom_ranged.sv - LFSR random generator with bounded rejection draws
//
// Purpose: on request, shifts the LFSR STEPS times, masks the result down
// to the smallest power-of-two range covering the limit and accepts it if
// below the limit; otherwise retries up to MAXTRIES times, then returns 0
// with fallback set. Optional zero guard: SC_REGRANDOM_ZEROGUARD_EN.
// Ports:
//   SC_RegRANDOM_CLOCK_50          in   clock, rising edge
//   SC_RegRANDOM_RESET_InHigh      in   asynchronous active-high reset
//   SC_RegRANDOM_run_InLow         in   low = free-run LFSR while idle
//   SC_RegRANDOM_seedLoad_InHigh   in   seed load, aborts any draw
//   SC_RegRANDOM_seed_InBUS        in   seed value
//   SC_RegRANDOM_req_InHigh        in   draw request (sampled when idle)
//   SC_RegRANDOM_limit_InBUS       in   exclusive bound N, 0 = full range
//   SC_RegRANDOM_data_OutBUS       out  drawn value, held between draws
//   SC_RegRANDOM_valid_OutHigh     out  one-cycle result strobe
//   SC_RegRANDOM_busy_OutHigh      out  draw in progress
//   SC_RegRANDOM_fallback_OutHigh  out  result came from exhausted tries
//   SC_RegRANDOM_state_OutBUS      out  raw LFSR register

module sc_regrandom_ranged
  import sc_regrandom_pkg::*;
#(
  parameter int unsigned RegRANDOM_DATAWIDTH = 8,
  parameter logic [15:0] RegRANDOM_SEED      = DEFAULT_SEED,
  parameter int unsigned RegRANDOM_STEPS     = RegRANDOM_DATAWIDTH,
  parameter int unsigned RegRANDOM_MAXTRIES  = 4
) (
  input  logic                           SC_RegRANDOM_CLOCK_50,
  input  logic                           SC_RegRANDOM_RESET_InHigh,
  input  logic                           SC_RegRANDOM_run_InLow,
  input  logic                           SC_RegRANDOM_seedLoad_InHigh,
  input  logic [RegRANDOM_DATAWIDTH-1:0] SC_RegRANDOM_seed_InBUS,
  input  logic                           SC_RegRANDOM_req_InHigh,
  input  logic [RegRANDOM_DATAWIDTH-1:0] SC_RegRANDOM_limit_InBUS,
  output logic [RegRANDOM_DATAWIDTH-1:0] SC_RegRANDOM_data_OutBUS,
  output logic                           SC_RegRANDOM_valid_OutHigh,
  output logic                           SC_RegRANDOM_busy_OutHigh,
  output logic                           SC_RegRANDOM_fallback_OutHigh,
  output logic [RegRANDOM_DATAWIDTH-1:0] SC_RegRANDOM_state_OutBUS
);

  localparam int unsigned      W          = RegRANDOM_DATAWIDTH;
  localparam logic [W-1:0]     SEED_W     = RegRANDOM_SEED[W-1:0];
  localparam logic [4:0]       STEPS_LAST = 5'(RegRANDOM_STEPS - 1);
  localparam logic [3:0]       MAXTRIES_C = 4'(RegRANDOM_MAXTRIES);

  rr_state_t    fsm_q;
  logic [4:0]   step_cnt_q;
  logic [3:0]   tries_q;
  logic [W-1:0] limit_q;
  logic [W-1:0] result_q;
  logic         result_fb_q;
  logic [W-1:0] data_q;
  logic         valid_q;
  logic         busy_q;
  logic         fallback_q;

  logic [W-1:0] lfsr_state;
  logic [W-1:0] mask;
  logic [W-1:0] candidate;
  logic         accept;
  logic         lfsr_advance;

  assign lfsr_advance = (fsm_q == ST_SHIFT) ||
                        ((fsm_q == ST_IDLE) && !SC_RegRANDOM_run_InLow);

  sc_regrandom_lfsr #(
    .WIDTH (W),
    .SEED  (SEED_W)
  ) u_lfsr (
    .clk        (SC_RegRANDOM_CLOCK_50),
    .rst        (SC_RegRANDOM_RESET_InHigh),
    .load       (SC_RegRANDOM_seedLoad_InHigh),
    .load_value (SC_RegRANDOM_seed_InBUS),
    .advance    (lfsr_advance),
    .state      (lfsr_state)
  );

  // Smear (N-1) down to all lower bits so the candidate range is the
  // smallest power of two covering N. N=0 wraps to all ones (full range),
  // N=1 gives an empty mask so the only candidate is 0.
  always_comb begin
    mask = limit_q - W'(1);
    for (int i = int'(W) - 2; i >= 0; i--) begin
      mask[i] = mask[i] | mask[i+1];
    end
    candidate = lfsr_state & mask;
    accept    = (limit_q == '0) || (candidate < limit_q);
  end

  // The result is staged in result_q at CHECK and only published in DONE,
  // so a seed load that aborts a draw in DONE leaves the outputs untouched.
  always_ff @(posedge SC_RegRANDOM_CLOCK_50 or posedge SC_RegRANDOM_RESET_InHigh) begin
    if (SC_RegRANDOM_RESET_InHigh) begin
      fsm_q       <= ST_IDLE;
      step_cnt_q  <= '0;
      tries_q     <= '0;
      limit_q     <= '0;
      result_q    <= '0;
      result_fb_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      fallback_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (SC_RegRANDOM_seedLoad_InHigh) begin
        fsm_q      <= ST_IDLE;
        busy_q     <= 1'b0;
        step_cnt_q <= '0;
      end else begin
        case (fsm_q)
          ST_IDLE: begin
            if (SC_RegRANDOM_req_InHigh) begin
              limit_q    <= SC_RegRANDOM_limit_InBUS;
              tries_q    <= '0;
              step_cnt_q <= '0;
              busy_q     <= 1'b1;
              fsm_q      <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (step_cnt_q == STEPS_LAST) begin
              step_cnt_q <= '0;
              fsm_q      <= ST_CHECK;
            end else begin
              step_cnt_q <= step_cnt_q + 5'd1;
            end
          end
          ST_CHECK: begin
            if (accept) begin
              result_q    <= candidate;
              result_fb_q <= 1'b0;
              fsm_q       <= ST_DONE;
            end else if ((tries_q + 4'd1) < MAXTRIES_C) begin
              tries_q <= tries_q + 4'd1;
              fsm_q   <= ST_SHIFT;
            end else begin
              result_q    <= '0;
              result_fb_q <= 1'b1;
              fsm_q       <= ST_DONE;
            end
          end
          ST_DONE: begin
            data_q     <= result_q;
            fallback_q <= result_fb_q;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
            fsm_q      <= ST_IDLE;
          end
          default: fsm_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign SC_RegRANDOM_data_OutBUS      = data_q;
  assign SC_RegRANDOM_valid_OutHigh    = valid_q;
  assign SC_RegRANDOM_busy_OutHigh     = busy_q;
  assign SC_RegRANDOM_fallback_OutHigh = fallback_q;
  assign SC_RegRANDOM_state_OutBUS     = lfsr_state;

endmodule

// File: tb/tb_sc_regrandom_ranged.sv
// tb/tb_sc_regrandom_ranged.sv - scoreboard bench for sc_regrandom_ranged

module tb_sc_regrandom_ranged;

  localparam int          STEPS    = 8;
  localparam int          MAXTRIES = 4;
  localparam logic [7:0]  SEED     = 8'h99;
  localparam logic [7:0]  TAPS     = 8'hB8;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_n;
  logic       seed_load;
  logic [7:0] seed;
  logic       req;
  logic [7:0] limit;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       fb;
  logic [7:0] state;

  sc_regrandom_ranged dut (
    .SC_RegRANDOM_CLOCK_50         (clk),
    .SC_RegRANDOM_RESET_InHigh     (rst),
    .SC_RegRANDOM_run_InLow        (run_n),
    .SC_RegRANDOM_seedLoad_InHigh  (seed_load),
    .SC_RegRANDOM_seed_InBUS       (seed),
    .SC_RegRANDOM_req_InHigh       (req),
    .SC_RegRANDOM_limit_InBUS      (limit),
    .SC_RegRANDOM_data_OutBUS      (data),
    .SC_RegRANDOM_valid_OutHigh    (valid),
    .SC_RegRANDOM_busy_OutHigh     (busy),
    .SC_RegRANDOM_fallback_OutHigh (fb),
    .SC_RegRANDOM_state_OutBUS     (state)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       fb;
    int         at;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] lfsr_m;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected draw.
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("draw_data", 32'(data), 32'(mon_e.data));
        check("draw_fallback", 32'(fb), 32'(mon_e.fb));
        check("draw_latency", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[6:0], ^(s & TAPS)};
  endfunction

  // Smallest all-ones value covering n-1; n=0 means the full range.
  function automatic logic [7:0] range_mask(input logic [7:0] n);
    logic [7:0] m;
    if (n == 8'd0) return 8'hFF;
    m = 8'h00;
    while (m < n - 8'd1) m = {m[6:0], 1'b1};
    return m;
  endfunction

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Called at a negedge; pushes expectation, pulses req, scrambles limit
  // after it has been sampled, and waits for the draw to finish.
  task automatic issue(input logic [7:0] n, input logic [7:0] e_data, input logic e_fb, input int rejects);
    exp_t e;
    e.data = e_data;
    e.fb   = e_fb;
    e.at   = cyc + 1 + (STEPS + 2) + rejects * (STEPS + 1);
    sb.push_back(e);
    last_data = e_data;
    req   = 1'b1;
    limit = n;
    @(negedge clk);
    req   = 1'b0;
    limit = ~n;
    wait_idle("draw_busy_timeout");
  endtask

  task automatic draw(input logic [7:0] n);
    logic [7:0] m;
    logic [7:0] cand;
    logic [7:0] d;
    logic       f;
    int         rej;
    m   = range_mask(n);
    rej = 0;
    forever begin
      repeat (STEPS) lfsr_m = step(lfsr_m);
      cand = lfsr_m & m;
      if (n == 8'd0 || cand < n) begin
        d = cand; f = 1'b0; break;
      end else if (rej + 1 < MAXTRIES) begin
        rej++;
      end else begin
        d = 8'h00; f = 1'b1; break;
      end
    end
    issue(n, d, f, rej);
  endtask

  task automatic load_seed(input logic [7:0] v);
    seed_load = 1'b1;
    seed      = v;
    @(negedge clk);
    seed_load = 1'b0;
`ifdef SC_REGRANDOM_ZEROGUARD_EN
    lfsr_m = (v == 8'h00) ? SEED : v;
`else
    lfsr_m = v;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    rst = 1'b1; run_n = 1'b1; seed_load = 1'b0; seed = 8'h00; req = 1'b0; limit = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(state), 32'h99);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fallback", 32'(fb), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("hold_state", 32'(state), 32'h99);

    run_n = 1'b0; @(negedge clk); run_n = 1'b1;
    check("step1_state", 32'(state), 32'h33);
    run_n = 1'b0; @(negedge clk); run_n = 1'b1;
    check("step2_state", 32'(state), 32'h66);

    // Full period of the maximal 8-bit sequence.
    load_seed(8'h99);
    early = 1'b0;
    run_n = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (i < 255 && state == 8'h99) early = 1'b1;
    end
    run_n = 1'b1;
    check("period_no_early_repeat", 32'(early), 32'd0);
    check("period_255", 32'(state), 32'h99);

    // Hand-computed draws from 0x99: 33 66 CD 9A 35 6A D4 A8.
    load_seed(8'h99);
    issue(8'd0, 8'hA8, 1'b0, 0);
    lfsr_m = 8'hA8;
    issue(8'd1, 8'h00, 1'b0, 0);
    repeat (STEPS) lfsr_m = step(lfsr_m);
    check("state_after_two_draws", 32'(state), 32'(lfsr_m));

    draw(8'd5);
    draw(8'd200);
    draw(8'd2);
    draw(8'd16);
    for (int i = 0; i < 40; i++) draw(8'd129);
    for (int i = 0; i < 1000; i++) draw(8'd3);

    // Seed load of zero during the 4th SHIFT cycle aborts the draw.
    req = 1'b1; limit = 8'd7;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    load_seed(8'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state), 32'(lfsr_m));
    check("abort_data_held", 32'(data), 32'(last_data));
    repeat (12) @(negedge clk);
`ifndef SC_REGRANDOM_ZEROGUARD_EN
    run_n = 1'b0;
    repeat (5) @(negedge clk);
    run_n = 1'b1;
    check("zero_lock_state", 32'(state), 32'h00);
`endif
    draw(8'd5);

    // Reset in the middle of CHECK.
    load_seed(8'h99);
    req = 1'b1; limit = 8'd0;
    @(negedge clk);
    req = 1'b0;
    repeat (STEPS) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midreset_state", 32'(state), 32'h99);
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_fallback", 32'(fb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
